// File: rtl/orient_to_position.sv
// orient_to_position
//   Turns the player's orientation word into head motion. On every game tick
//   in RUN the head advances STEP pixels along the orientation in effect, and
//   the linear pixel address location = y*SCREEN_W + x is registered for the
//   trail/collision writer. A small IDLE/RUN/CRASH FSM gates the motion.
//
//   Build option: define WRAP_EN to make the head wrap around the screen
//   edges instead of crashing into them. Without it (default build), hitting
//   a wall moves the FSM to CRASH.
//
// Ports
//   clock       in   1   system clock
//   resetn      in   1   synchronous active-low reset
//   start       in   1   pulse: launch the bike from IDLE or CRASH
//   tick        in   1   pulse: perform one move while in RUN
//   orient_in   in   32  requested orientation (1, -1, SCREEN_W, -SCREEN_W)
//   orient_out  out  32  orientation in effect
//   location    out  32  y*SCREEN_W + x of the head
//   x, y        out  10  head column / row
//   move_valid  out  1   pulse: x/y/location just updated by a move
//   running     out  1   FSM in RUN
//   crashed     out  1   FSM in CRASH
//
// State table
//   state   | meaning
//   S_IDLE  | out of reset, waiting for start
//   S_RUN   | head moves on each tick
//   S_CRASH | head hit a wall, waiting for start to relaunch

module orient_to_position #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int STEP         = 10,
  parameter int START_X      = 320,
  parameter int START_Y      = 240,
  parameter int START_ORIENT = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        tick,
  input  logic [31:0] orient_in,
  output logic [31:0] orient_out,
  output logic [31:0] location,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        move_valid,
  output logic        running,
  output logic        crashed
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CRASH = 2'd2
  } state_t;

  localparam logic [31:0] O_RIGHT   = 32'd1;
  localparam logic [31:0] O_LEFT    = 32'hFFFF_FFFF;
  localparam logic [31:0] O_DOWN    = 32'(SCREEN_W);
  localparam logic [31:0] O_UP      = 32'(-SCREEN_W);
  localparam logic [31:0] W_U       = 32'(SCREEN_W);
  localparam logic [31:0] H_U       = 32'(SCREEN_H);
  localparam logic [31:0] STEP_U    = 32'(STEP);
  localparam logic [9:0]  START_X_U = 10'(START_X);
  localparam logic [9:0]  START_Y_U = 10'(START_Y);
  localparam logic [31:0] START_O_U = 32'(START_ORIENT);
  localparam logic [31:0] START_LOC = 32'(START_Y * SCREEN_W + START_X);

  state_t      state, state_nx;
  logic [9:0]  x_nx, y_nx;
  logic [31:0] orient_nx;
  logic [31:0] location_nx;
  logic        move_nx;
  logic        legal, accept;
  logic [31:0] dir;
  logic [31:0] xw, yw;

  assign xw = {22'd0, x};
  assign yw = {22'd0, y};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      x          <= START_X_U;
      y          <= START_Y_U;
      orient_out <= START_O_U;
      location   <= START_LOC;
      move_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      orient_out <= orient_nx;
      location   <= location_nx;
      move_valid <= move_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    x_nx      = x;
    y_nx      = y;
    orient_nx = orient_out;
    move_nx   = 1'b0;
    legal     = 1'b0;
    accept    = 1'b0;
    dir       = orient_out;
    case (state)
      S_IDLE, S_CRASH: begin
        if (start) begin
          state_nx  = S_RUN;
          x_nx      = START_X_U;
          y_nx      = START_Y_U;
          orient_nx = START_O_U;
        end
      end
      S_RUN: begin
        if (tick) begin
          legal = (orient_in == O_RIGHT) || (orient_in == O_LEFT) ||
                  (orient_in == O_DOWN)  || (orient_in == O_UP);
          // A reversal would drive the head straight into its own trail.
          accept    = legal && (orient_in != (~orient_out + 32'd1));
          dir       = accept ? orient_in : orient_out;
          orient_nx = dir;
          move_nx   = 1'b1;
          // Edge tests precede the add/subtract so x/y never underflow.
          case (dir)
            O_RIGHT: begin
              if (xw + STEP_U > W_U - 32'd1) begin
`ifdef WRAP_EN
                x_nx = 10'(xw + STEP_U - W_U);
`else
                move_nx  = 1'b0;
                state_nx = S_CRASH;
`endif
              end else begin
                x_nx = 10'(xw + STEP_U);
              end
            end
            O_LEFT: begin
              if (xw < STEP_U) begin
`ifdef WRAP_EN
                x_nx = 10'(xw + W_U - STEP_U);
`else
                move_nx  = 1'b0;
                state_nx = S_CRASH;
`endif
              end else begin
                x_nx = 10'(xw - STEP_U);
              end
            end
            O_DOWN: begin
              if (yw + STEP_U > H_U - 32'd1) begin
`ifdef WRAP_EN
                y_nx = 10'(yw + STEP_U - H_U);
`else
                move_nx  = 1'b0;
                state_nx = S_CRASH;
`endif
              end else begin
                y_nx = 10'(yw + STEP_U);
              end
            end
            O_UP: begin
              if (yw < STEP_U) begin
`ifdef WRAP_EN
                y_nx = 10'(yw + H_U - STEP_U);
`else
                move_nx  = 1'b0;
                state_nx = S_CRASH;
`endif
              end else begin
                y_nx = 10'(yw - STEP_U);
              end
            end
            default: move_nx = 1'b0;
          endcase
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign location_nx = 32'(y_nx) * W_U + 32'(x_nx);

  assign running = (state == S_RUN);
  assign crashed = (state == S_CRASH);

endmodule

// File: tb/tb_orient_to_position.sv
module tb_orient_to_position;

  localparam int W = 640;
  localparam int H = 480;
  localparam int ST = 10;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] orient_in = 32'd1;
  logic [31:0] orient_out, location;
  logic [9:0]  x, y;
  logic        move_valid, running, crashed;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state: plain signed integers, state 0 idle / 1 run / 2 crash
  int m_x = 320, m_y = 240, m_o = 1, m_st = 0, m_v = 0;

  orient_to_position dut (
    .clock(clock), .resetn(resetn), .start(start), .tick(tick),
    .orient_in(orient_in), .orient_out(orient_out), .location(location),
    .x(x), .y(y), .move_valid(move_valid), .running(running), .crashed(crashed)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rn, st, tk;
    logic [31:0] oi;
    int          ex, ey;
    logic [31:0] eo;
    logic        ev, er, ec;
  } vec_t;

  function automatic logic [86:0] act_pack();
    return {x, y, orient_out, location, move_valid, running, crashed};
  endfunction

  function automatic logic [86:0] exp_pack(int ex, int ey, logic [31:0] eo,
                                           logic ev, logic er, logic ec);
    return {10'(ex), 10'(ey), eo, 32'(ey * W + ex), ev, er, ec};
  endfunction

  task automatic model_step(input logic rn, input logic st, input logic tk,
                            input logic [31:0] oi);
    int o, nx, ny;
    o = $signed(oi);
    m_v = 0;
    if (!rn) begin
      m_x = 320; m_y = 240; m_o = 1; m_st = 0;
    end else if (m_st != 1) begin
      if (st) begin
        m_x = 320; m_y = 240; m_o = 1; m_st = 1;
      end
    end else if (tk) begin
      if ((o == 1 || o == -1 || o == W || o == -W) && o != -m_o) m_o = o;
      nx = m_x; ny = m_y;
      if (m_o == 1) nx = m_x + ST;
      else if (m_o == -1) nx = m_x - ST;
      else if (m_o == W) ny = m_y + ST;
      else ny = m_y - ST;
      if (nx < 0 || nx > W - 1 || ny < 0 || ny > H - 1) begin
`ifdef WRAP_EN
        m_x = (nx + W) % W; m_y = (ny + H) % H; m_v = 1;
`else
        m_st = 2;
`endif
      end else begin
        m_x = nx; m_y = ny; m_v = 1;
      end
    end
  endtask

  task automatic drive(input logic rn, input logic st, input logic tk,
                       input logic [31:0] oi);
    @(negedge clock);
    resetn = rn; start = st; tick = tk; orient_in = oi;
    @(posedge clock);
    model_step(rn, st, tk, oi);
    #1;
  endtask

  task automatic check(input string name, input logic [86:0] exp);
    logic [86:0] act;
    act = act_pack();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d o=%h loc=%0d v=%b r=%b c=%b, want x=%0d y=%0d o=%h loc=%0d v=%b r=%b c=%b",
               name, act[86:77], act[76:67], act[66:35], act[34:3], act[2], act[1], act[0],
               exp[86:77], exp[76:67], exp[66:35], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_model(input string name);
    check(name, exp_pack(m_x, m_y, 32'(m_o), m_v[0], m_st == 1, m_st == 2));
  endtask

  vec_t tab[15];
  logic [31:0] want_o;

  initial begin
    tab[0]  = '{1'b0, 1'b0, 1'b0, 32'd1,         320, 240, 32'd1,         1'b0, 1'b0, 1'b0};
    tab[1]  = '{1'b1, 1'b1, 1'b1, 32'd1,         320, 240, 32'd1,         1'b0, 1'b1, 1'b0};
    tab[2]  = '{1'b1, 1'b0, 1'b1, 32'd1,         330, 240, 32'd1,         1'b1, 1'b1, 1'b0};
    tab[3]  = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF,  340, 240, 32'd1,         1'b1, 1'b1, 1'b0};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 32'd1,         340, 240, 32'd1,         1'b0, 1'b1, 1'b0};
    tab[5]  = '{1'b1, 1'b0, 1'b1, 32'hFFFFFD80,  340, 230, 32'hFFFFFD80,  1'b1, 1'b1, 1'b0};
    tab[6]  = '{1'b1, 1'b0, 1'b1, 32'd0,         340, 220, 32'hFFFFFD80,  1'b1, 1'b1, 1'b0};
    tab[7]  = '{1'b1, 1'b0, 1'b1, 32'd5,         340, 210, 32'hFFFFFD80,  1'b1, 1'b1, 1'b0};
    tab[8]  = '{1'b1, 1'b0, 1'b1, 32'd640,       340, 200, 32'hFFFFFD80,  1'b1, 1'b1, 1'b0};
    tab[9]  = '{1'b1, 1'b0, 1'b1, 32'd1,         350, 200, 32'd1,         1'b1, 1'b1, 1'b0};
    tab[10] = '{1'b1, 1'b1, 1'b0, 32'd1,         350, 200, 32'd1,         1'b0, 1'b1, 1'b0};
    tab[11] = '{1'b0, 1'b0, 1'b1, 32'd1,         320, 240, 32'd1,         1'b0, 1'b0, 1'b0};
    tab[12] = '{1'b1, 1'b0, 1'b1, 32'd1,         320, 240, 32'd1,         1'b0, 1'b0, 1'b0};
    tab[13] = '{1'b1, 1'b1, 1'b0, 32'd1,         320, 240, 32'd1,         1'b0, 1'b1, 1'b0};
    tab[14] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFF,  330, 240, 32'd1,         1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      drive(tab[i].rn, tab[i].st, tab[i].tk, tab[i].oi);
      check($sformatf("table[%0d]", i),
            exp_pack(tab[i].ex, tab[i].ey, tab[i].eo, tab[i].ev, tab[i].er, tab[i].ec));
    end

    // right wall: march to x=630 then one more tick
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'd1);
      check("march_right", exp_pack(m_x, m_y, 32'(m_o), m_v[0], m_st == 1, m_st == 2));
    end
    check("at_630", exp_pack(630, 240, 32'd1, 1'b1, 1'b1, 1'b0));
    drive(1'b1, 1'b0, 1'b1, 32'd1);
`ifdef WRAP_EN
    check("right_wrap", exp_pack(0, 240, 32'd1, 1'b1, 1'b1, 1'b0));
`else
    check("right_crash", exp_pack(630, 240, 32'd1, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'd640);
      check("crash_tick", exp_pack(630, 240, 32'd1, 1'b0, 1'b0, 1'b1));
    end
    drive(1'b1, 1'b1, 1'b0, 32'd1);
    check("restart", exp_pack(320, 240, 32'd1, 1'b0, 1'b1, 1'b0));
`endif

    // top wall from the start position
    drive(1'b1, 1'b1, 1'b0, 32'd1);
    want_o = 32'hFFFFFD80;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b0, 1'b1, want_o);
      check_model("march_up");
    end
    drive(1'b1, 1'b0, 1'b1, want_o);
`ifdef WRAP_EN
    check("up_wrap", exp_pack(m_x, 470, want_o, 1'b1, 1'b1, 1'b0));
`else
    check("up_crash", exp_pack(m_x, 0, want_o, 1'b0, 1'b0, 1'b1));
`endif

    // randomized run against the reference model
    begin
      logic [31:0] want;
      logic rn, st, tk;
      int pick;
      want = 32'd1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          pick = $urandom_range(0, 7);
          case (pick)
            0: want = 32'd1;
            1: want = 32'hFFFFFFFF;
            2: want = 32'd640;
            3: want = 32'hFFFFFD80;
            4: want = 32'd0;
            5: want = 32'd5;
            6: want = $urandom;
            default: want = 32'd1;
          endcase
        end
        rn = ($urandom_range(0, 299) != 0);
        st = ($urandom_range(0, 29) == 0);
        tk = ($urandom_range(0, 2) != 0);
        drive(rn, st, tk, want);
        check_model("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
